seq_bus_arb: RTL and testbench

SEQ_BUS_ARB -- requirements
Module: seq_bus_arb

---
 rtl/seq_bus_arb.sv | 110 +++++++++++
 tb/tb_seq_bus_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_bus_arb.sv
// Fixed-priority sequential bus arbiter with a T1..T4 bus cycle and registered strobes.
// Optional wait states in T2 are enabled by defining SEQ_BUS_WAIT_EN.
module seq_bus_arb #(
    parameter int DMA_PRIO = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_wr,
    input  logic       dma_req,
    input  logic       wait_n,
    output logic       gnt_fetch,
    output logic       gnt_data,
    output logic       gnt_dma,
    output logic       nmreq,
    output logic       nrd,
    output logic       nwr,
    output logic [2:0] tstate,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [2:0] gnt, gnt_nx;        // {fetch, data, dma}
    logic       wr, wr_nx;
    logic       active_nx;
    logic       nmreq_nx, nrd_nx, nwr_nx, done_nx;
    logic       wait_hold;

`ifdef SEQ_BUS_WAIT_EN
    assign wait_hold = ~wait_n;
`else
    logic unused_wait;
    assign wait_hold   = 1'b0;
    assign unused_wait = wait_n;
`endif

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        wr_nx    = wr;
        case (state)
            IDLE, T4: begin
                if (dma_req || data_req || fetch_req) begin
                    state_nx = T1;
                    wr_nx    = 1'b0;
                    if ((DMA_PRIO != 0) && dma_req) begin
                        gnt_nx = 3'b001;
                    end else if (data_req) begin
                        gnt_nx = 3'b010;
                        wr_nx  = data_wr;
                    end else if (fetch_req) begin
                        gnt_nx = 3'b100;
                    end else begin
                        gnt_nx = 3'b001;
                    end
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    wr_nx    = 1'b0;
                end
            end
            T1:      state_nx = T2;
            T2:      state_nx = wait_hold ? T2 : T3;
            T3:      state_nx = T4;
            default: state_nx = IDLE;
        endcase

        // Strobes are derived from the next state so they leave the flops aligned with tstate.
        active_nx = (state_nx == T1) || (state_nx == T2) || (state_nx == T3);
        nmreq_nx  = ~active_nx;
        nrd_nx    = ~(active_nx && !wr_nx);
        nwr_nx    = ~(((state_nx == T2) || (state_nx == T3)) && wr_nx);
        done_nx   = (state_nx == T4);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            gnt   <= '0;
            wr    <= 1'b0;
            nmreq <= 1'b1;
            nrd   <= 1'b1;
            nwr   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            wr    <= wr_nx;
            nmreq <= nmreq_nx;
            nrd   <= nrd_nx;
            nwr   <= nwr_nx;
            done  <= done_nx;
        end
    end

    assign gnt_fetch = gnt[2];
    assign gnt_data  = gnt[1];
    assign gnt_dma   = gnt[0];
    assign tstate    = state;

endmodule

// File: tb/tb_seq_bus_arb.sv
// Scoreboard bench for seq_bus_arb: one instance per DMA_PRIO value, expected
// per-clock bus snapshots queued with the stimulus and popped each clock.
module tb_seq_bus_arb;

    localparam logic [2:0] GF = 3'b100;
    localparam logic [2:0] GD = 3'b010;
    localparam logic [2:0] GM = 3'b001;
`ifdef SEQ_BUS_WAIT_EN
    localparam int unsigned WAITS = 3;
`else
    localparam int unsigned WAITS = 0;
`endif

    logic clk, res, wait_n;
    logic fetch_req, data_req, data_wr, dma_req;
    logic f0, d0, w0, m0;
    logic gf1, gd1, gm1, nmreq1, nrd1, nwr1, done1;
    logic gf0, gd0, gm0, nmreq0, nrd0, nwr0, done0;
    logic [2:0] ts1, ts0;
    logic [9:0] obs1, obs0;

    logic [9:0] q1[$];
    logic [9:0] q0[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    string tag;

    seq_bus_arb #(.DMA_PRIO(1)) dut1 (
        .clk(clk), .res(res), .fetch_req(fetch_req), .data_req(data_req),
        .data_wr(data_wr), .dma_req(dma_req), .wait_n(wait_n),
        .gnt_fetch(gf1), .gnt_data(gd1), .gnt_dma(gm1), .nmreq(nmreq1),
        .nrd(nrd1), .nwr(nwr1), .tstate(ts1), .done(done1)
    );

    seq_bus_arb #(.DMA_PRIO(0)) dut0 (
        .clk(clk), .res(res), .fetch_req(f0), .data_req(d0),
        .data_wr(w0), .dma_req(m0), .wait_n(wait_n),
        .gnt_fetch(gf0), .gnt_data(gd0), .gnt_dma(gm0), .nmreq(nmreq0),
        .nrd(nrd0), .nwr(nwr0), .tstate(ts0), .done(done0)
    );

    assign obs1 = {ts1, gf1, gd1, gm1, nmreq1, nrd1, nwr1, done1};
    assign obs0 = {ts0, gf0, gd0, gm0, nmreq0, nrd0, nwr0, done0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot: {tstate, gnt_fetch, gnt_data, gnt_dma, nmreq, nrd, nwr, done}
    function automatic logic [9:0] mk(input logic [2:0] ts, input logic [2:0] g, input logic wr);
        logic act, wph;
        act = (ts >= 3'd1) && (ts <= 3'd3);
        wph = (ts == 3'd2) || (ts == 3'd3);
        return {ts, (ts == 3'd0) ? 3'b000 : g, ~act, ~(act & ~wr), ~(wph & wr), ts == 3'd4};
    endfunction

    task automatic push(input bit which, input logic [9:0] s);
        if (which) q1.push_back(s);
        else       q0.push_back(s);
    endtask

    task automatic push_cycle(input bit which, input logic [2:0] g, input logic wr,
                              input int unsigned waits);
        push(which, mk(3'd1, g, wr));
        for (int unsigned i = 0; i <= waits; i++) push(which, mk(3'd2, g, wr));
        push(which, mk(3'd3, g, wr));
        push(which, mk(3'd4, g, wr));
    endtask

    task automatic chk(input string name, input logic [9:0] o, input logic [9:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", name, o, e);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk({tag, "/prio1"}, obs1, e);
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk({tag, "/prio0"}, obs0, e);
        end
    endtask

    initial begin
        int unsigned L;
        int unsigned dones;

        res = 1'b1; wait_n = 1'b1;
        fetch_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; dma_req = 1'b0;
        f0 = 1'b0; d0 = 1'b0; w0 = 1'b0; m0 = 1'b0;
        #1;
        chk("reset_prio1", obs1, mk(3'd0, 3'b000, 1'b0));
        chk("reset_prio0", obs0, mk(3'd0, 3'b000, 1'b0));
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        tag = "idle_after_reset";
        push(1, mk(3'd0, 3'b000, 1'b0));
        push(0, mk(3'd0, 3'b000, 1'b0));
        tick();

        // Single fetch, request held for one clock only.
        tag = "fetch_read";
        fetch_req = 1'b1;
        push_cycle(1, GF, 1'b0, 0);
        push(1, mk(3'd0, 3'b000, 1'b0));
        tick();
        fetch_req = 1'b0;
        repeat (4) tick();

        // Data write: nwr only in T2/T3, nrd never low.
        tag = "data_write";
        data_req = 1'b1; data_wr = 1'b1;
        push_cycle(1, GD, 1'b1, 0);
        push(1, mk(3'd0, 3'b000, 1'b0));
        repeat (4) tick();
        data_req = 1'b0; data_wr = 1'b0;
        tick();

        // All three requesting on both priority settings, each dropped after its done.
        tag = "priority";
        dma_req = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
        m0 = 1'b1; d0 = 1'b1; f0 = 1'b1;
        push_cycle(1, GM, 1'b0, 0);
        push_cycle(1, GD, 1'b0, 0);
        push_cycle(1, GF, 1'b0, 0);
        push(1, mk(3'd0, 3'b000, 1'b0));
        push_cycle(0, GD, 1'b0, 0);
        push_cycle(0, GF, 1'b0, 0);
        push_cycle(0, GM, 1'b0, 0);
        push(0, mk(3'd0, 3'b000, 1'b0));
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 4)  begin dma_req = 1'b0;   d0 = 1'b0; end
            if (k == 8)  begin data_req = 1'b0;  f0 = 1'b0; end
            if (k == 12) begin fetch_req = 1'b0; m0 = 1'b0; end
        end

        // Asynchronous reset in T2 of a write.
        tag = "reset_mid_write";
        data_req = 1'b1; data_wr = 1'b1;
        push(1, mk(3'd1, GD, 1'b1));
        push(1, mk(3'd2, GD, 1'b1));
        repeat (2) tick();
        data_req = 1'b0; data_wr = 1'b0;
        #2 res = 1'b1;
        #1 chk("async_reset", obs1, mk(3'd0, 3'b000, 1'b0));
        #2 res = 1'b0;
        push(1, mk(3'd0, 3'b000, 1'b0));
        tick();

        // Wait states in T2 (ignored when the feature is compiled out).
        tag = "wait_states";
        L = 4 + WAITS;
        dones = 0;
        dma_req = 1'b1;
        push_cycle(1, GM, 1'b0, WAITS);
        push(1, mk(3'd0, 3'b000, 1'b0));
        for (int unsigned k = 1; k <= L + 1; k++) begin
            tick();
            if (done1 === 1'b1) dones++;
            if (k == 1) wait_n = 1'b0;
            if (k == 5) wait_n = 1'b1;
            if (k == L) dma_req = 1'b0;
        end
        n_cmp++;
        assert (dones == 1) else begin
            n_err++;
            $error("FAIL wait_done_count observed=%0d expected=1", dones);
        end

        // Fetch request dropped in T2 still completes.
        tag = "drop_in_t2";
        fetch_req = 1'b1;
        push_cycle(1, GF, 1'b0, 0);
        push(1, mk(3'd0, 3'b000, 1'b0));
        repeat (2) tick();
        fetch_req = 1'b0;
        repeat (3) tick();

        // Data read held through its done starts a second back-to-back cycle.
        tag = "held_req_back_to_back";
        data_req = 1'b1; data_wr = 1'b0;
        push_cycle(1, GD, 1'b0, 0);
        push_cycle(1, GD, 1'b0, 0);
        push(1, mk(3'd0, 3'b000, 1'b0));
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 8) data_req = 1'b0;
        end

        n_cmp++;
        assert (q1.size() == 0 && q0.size() == 0) else begin
            n_err++;
            $error("FAIL queue_drain observed=%0d/%0d expected=0/0", q1.size(), q0.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
